hazard_fwd_ctrl: RTL and testbench

//  Parametrised forwarding + hazard controller for the pipelined RV32I core. It generalises
//  EX/MEM and MEM/WB forwarding to NUM_FWD later stages and NUM_SRC operands. It adds:

---
 rtl/hazard_fwd_ctrl_pkg.sv | 29 ++
 rtl/hazard_fwd_ctrl_if.sv | 64 ++++++
 rtl/hazard_fwd_ctrl_mc_scoreboard.sv | 75 +++++++
 rtl/hazard_fwd_ctrl.sv | 106 ++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/hazard_fwd_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hazard_fwd_ctrl_pkg                                          |
// | Description : Shared constants, types and the source-match helper for the  |
// |               forwarding / hazard controller.                              |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package hazard_fwd_ctrl_pkg;

    // Register address width; address 0 is the hard-wired zero register.
    localparam int REG_AW = 5;

    // Forwarding select for the default configuration (2 later stages).
    typedef logic [1:0] fwd_sel_t;
    localparam fwd_sel_t FWD_REGFILE = 2'd0;

    typedef logic [REG_AW-1:0] reg_addr_t;

    // True when a source that is actually read depends on a writer whose
    // destination is a real register. A match on x0 never counts.
    function automatic logic match_src(input reg_addr_t rs,
                                       input logic      used,
                                       input reg_addr_t rd,
                                       input logic      we);
        return used && we && (rd != '0) && (rs == rd);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_fwd_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hazard_fwd_ctrl_if                                           |
// | Description : Pipeline-side bundle of the hazard/forwarding controller.    |
// |               i_* are driven by the pipeline (master), o_* by the          |
// |               controller (slave).                                          |
// |   i_de_rs/_used, i_de_is_mc        DE-stage sources and multicycle flag    |
// |   i_ex_rs/_used, i_ex_rd, i_ex_*   EX-stage operands and writer info       |
// |   i_fwd_rd, i_fwd_regwrite         destinations of later stages            |
// |   i_mc_start/_rd/_lat              multicycle issue                        |
// |   o_fwd_sel, o_stall_de, o_bubble_ex, o_mc_*, o_stall_cycles  results      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface hazard_fwd_ctrl_if
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int NUM_FWD = 2,
    parameter int LAT_W   = 6,
    parameter int CNT_W   = 32
);
    localparam int SEL_W = $clog2(NUM_FWD + 1);

    logic [NUM_SRC*REG_AW-1:0] i_de_rs;
    logic [NUM_SRC-1:0]        i_de_rs_used;
    logic                      i_de_is_mc;
    logic [NUM_SRC*REG_AW-1:0] i_ex_rs;
    logic [NUM_SRC-1:0]        i_ex_rs_used;
    logic [REG_AW-1:0]         i_ex_rd;
    logic                      i_ex_regwrite;
    logic                      i_ex_is_load;
    logic [NUM_FWD*REG_AW-1:0] i_fwd_rd;
    logic [NUM_FWD-1:0]        i_fwd_regwrite;
    logic                      i_mc_start;
    logic [REG_AW-1:0]         i_mc_rd;
    logic [LAT_W-1:0]          i_mc_lat;

    logic [NUM_SRC*SEL_W-1:0]  o_fwd_sel;
    logic                      o_stall_de;
    logic                      o_bubble_ex;
    logic                      o_mc_busy;
    logic                      o_mc_wb_valid;
    logic [REG_AW-1:0]         o_mc_wb_rd;
    logic                      o_mc_err;
    logic [CNT_W-1:0]          o_stall_cycles;

    modport master (
        output i_de_rs, i_de_rs_used, i_de_is_mc, i_ex_rs, i_ex_rs_used, i_ex_rd,
               i_ex_regwrite, i_ex_is_load, i_fwd_rd, i_fwd_regwrite,
               i_mc_start, i_mc_rd, i_mc_lat,
        input  o_fwd_sel, o_stall_de, o_bubble_ex, o_mc_busy, o_mc_wb_valid,
               o_mc_wb_rd, o_mc_err, o_stall_cycles
    );

    modport slave (
        input  i_de_rs, i_de_rs_used, i_de_is_mc, i_ex_rs, i_ex_rs_used, i_ex_rd,
               i_ex_regwrite, i_ex_is_load, i_fwd_rd, i_fwd_regwrite,
               i_mc_start, i_mc_rd, i_mc_lat,
        output o_fwd_sel, o_stall_de, o_bubble_ex, o_mc_busy, o_mc_wb_valid,
               o_mc_wb_rd, o_mc_err, o_stall_cycles
    );

endinterface
`default_nettype wire

// File: rtl/hazard_fwd_ctrl_mc_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hazard_fwd_ctrl_mc_scoreboard                                |
// | Description : One-entry scoreboard for the multicycle unit. Tracks the     |
// |               pending destination and a countdown; pulses write-back on    |
// |               the last cycle; flags a sticky error on issue while busy.    |
// |   clk, rst_n               clock, async active-low reset                   |
// |   i_mc_start/_rd/_lat      issue strobe, destination, latency (0 -> 1)     |
// |   o_busy, o_rd             entry valid and its destination                 |
// |   o_wb_valid, o_wb_rd      completion pulse and completing destination     |
// |   o_err                    sticky issue-while-busy error                   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module hazard_fwd_ctrl_mc_scoreboard
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int LAT_W = 6
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              i_mc_start,
    input  wire logic [REG_AW-1:0] i_mc_rd,
    input  wire logic [LAT_W-1:0]  i_mc_lat,
    output logic                   o_busy,
    output logic [REG_AW-1:0]      o_rd,
    output logic                   o_wb_valid,
    output logic [REG_AW-1:0]      o_wb_rd,
    output logic                   o_err
);

    logic              r_valid;
    logic [REG_AW-1:0] r_rd;
    logic [LAT_W-1:0]  r_cnt;
    logic              r_err;

    logic              w_done;
    logic [LAT_W-1:0]  w_lat_eff;

    assign w_done    = r_valid && (r_cnt == LAT_W'(1));
    assign w_lat_eff = (i_mc_lat == '0) ? LAT_W'(1) : i_mc_lat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_rd    <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            // An issue while the entry is occupied (including its completion
            // cycle) is dropped; the entry in flight is left untouched.
            if (i_mc_start && r_valid) begin
                r_err <= 1'b1;
            end

            if (i_mc_start && !r_valid) begin
                r_valid <= 1'b1;
                r_rd    <= i_mc_rd;
                r_cnt   <= w_lat_eff;
            end else if (r_valid) begin
                r_cnt <= r_cnt - LAT_W'(1);
                if (w_done) begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

    assign o_busy     = r_valid;
    assign o_rd       = r_rd;
    assign o_wb_valid = w_done;
    assign o_wb_rd    = w_done ? r_rd : '0;
    assign o_err      = r_err;

endmodule
`default_nettype wire

// File: rtl/hazard_fwd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hazard_fwd_ctrl                                              |
// | Description : Forwarding select, load-use / multicycle stall generation    |
// |               and saturating stall-cycle counter for the RV32I pipeline.   |
// |   clk, rst_n   clock, async active-low reset                               |
// |   bus          hazard_fwd_ctrl_if.slave: DE/EX operands, later-stage        |
// |                writers, multicycle issue in; fwd_sel, stall_de, bubble_ex, |
// |                multicycle status and stall_cycles out                      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module hazard_fwd_ctrl
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int NUM_FWD = 2,
    parameter int LAT_W   = 6,
    parameter int CNT_W   = 32
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    hazard_fwd_ctrl_if.slave bus
);

    localparam int SEL_W = $clog2(NUM_FWD + 1);

    logic                     w_sb_busy;
    logic [REG_AW-1:0]        w_sb_rd;
    logic                     w_sb_wb_valid;
    logic [REG_AW-1:0]        w_sb_wb_rd;
    logic                     w_sb_err;

    logic [NUM_SRC*SEL_W-1:0] w_fwd_sel;
    logic                     w_load_use;
    logic                     w_sb_dep;
    logic                     w_stall;
    logic [CNT_W-1:0]         r_stall_cycles;

    hazard_fwd_ctrl_mc_scoreboard #(
        .LAT_W (LAT_W)
    ) u_mc_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_mc_start (bus.i_mc_start),
        .i_mc_rd    (bus.i_mc_rd),
        .i_mc_lat   (bus.i_mc_lat),
        .o_busy     (w_sb_busy),
        .o_rd       (w_sb_rd),
        .o_wb_valid (w_sb_wb_valid),
        .o_wb_rd    (w_sb_wb_rd),
        .o_err      (w_sb_err)
    );

    // Walk from the oldest stage to the youngest so the youngest match is
    // the last assignment and wins.
    always_comb begin
        w_fwd_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = NUM_FWD - 1; k >= 0; k--) begin
                if (match_src(bus.i_ex_rs[i*REG_AW +: REG_AW], bus.i_ex_rs_used[i],
                              bus.i_fwd_rd[k*REG_AW +: REG_AW], bus.i_fwd_regwrite[k])) begin
                    w_fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
                end
            end
        end
    end

    // The scoreboard still reports busy in its completion cycle, so a
    // dependent instruction keeps stalling until the write has landed.
    always_comb begin
        w_load_use = 1'b0;
        w_sb_dep   = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (match_src(bus.i_de_rs[i*REG_AW +: REG_AW], bus.i_de_rs_used[i],
                          bus.i_ex_rd, bus.i_ex_is_load && bus.i_ex_regwrite)) begin
                w_load_use = 1'b1;
            end
            if (match_src(bus.i_de_rs[i*REG_AW +: REG_AW], bus.i_de_rs_used[i],
                          w_sb_rd, w_sb_busy)) begin
                w_sb_dep = 1'b1;
            end
        end
    end

    // Combinational outputs are forced low while reset is asserted.
    assign w_stall = rst_n && (w_load_use || w_sb_dep || (bus.i_de_is_mc && w_sb_busy));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
        end else if (w_stall && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
        end
    end

    assign bus.o_fwd_sel      = rst_n ? w_fwd_sel : '0;
    assign bus.o_stall_de     = w_stall;
    assign bus.o_bubble_ex    = w_stall;
    assign bus.o_mc_busy      = w_sb_busy;
    assign bus.o_mc_wb_valid  = w_sb_wb_valid;
    assign bus.o_mc_wb_rd     = w_sb_wb_rd;
    assign bus.o_mc_err       = w_sb_err;
    assign bus.o_stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_hazard_fwd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_hazard_fwd_ctrl                                           |
// | Description : Directed-vector bench with an expectation queue per cycle    |
// |               and a write-back queue, drained by an independent monitor.   |
// |               Counter width is reduced to 4 so saturation is reachable.    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_hazard_fwd_ctrl;
    import hazard_fwd_ctrl_pkg::*;

    localparam int CW = 4;

    typedef struct {
        string      nm;
        logic [3:0] fwd;
        logic       stall;
        logic       busy;
        logic       wbv;
        logic       err;
        logic [3:0] cnt;
    } exp_t;

    logic clk;
    logic rst_n;

    hazard_fwd_ctrl_if #(.NUM_SRC(2), .NUM_FWD(2), .LAT_W(6), .CNT_W(CW)) bus ();

    hazard_fwd_ctrl #(.NUM_SRC(2), .NUM_FWD(2), .LAT_W(6), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t              expq[$];
    logic [REG_AW-1:0] wbq[$];
    int                n_tests = 0;
    int                n_fail  = 0;
    int                model_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            chk({e.nm, ".fwd_sel"},      int'(bus.o_fwd_sel),      int'(e.fwd));
            chk({e.nm, ".stall_de"},     int'(bus.o_stall_de),     int'(e.stall));
            chk({e.nm, ".bubble_ex"},    int'(bus.o_bubble_ex),    int'(e.stall));
            chk({e.nm, ".mc_busy"},      int'(bus.o_mc_busy),      int'(e.busy));
            chk({e.nm, ".mc_wb_valid"},  int'(bus.o_mc_wb_valid),  int'(e.wbv));
            chk({e.nm, ".mc_err"},       int'(bus.o_mc_err),       int'(e.err));
            chk({e.nm, ".stall_cycles"}, int'(bus.o_stall_cycles), int'(e.cnt));
        end
        if (bus.o_mc_wb_valid === 1'b1) begin
            if (wbq.size() == 0) begin
                chk("wb_unexpected", 1, 0);
            end else begin
                chk("wb_rd", int'(bus.o_mc_wb_rd), int'(wbq.pop_front()));
            end
        end
    end

    // Push the expectation for the current cycle, then advance one cycle.
    task automatic step(input string nm, input logic [3:0] fwd, input logic stall,
                        input logic busy, input logic wbv, input logic err);
        exp_t e;
        e.nm = nm; e.fwd = fwd; e.stall = stall; e.busy = busy;
        e.wbv = wbv; e.err = err; e.cnt = 4'(model_cnt);
        expq.push_back(e);
        if (stall && model_cnt < 15) model_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_de_rs = '0;  bus.i_de_rs_used = '0; bus.i_de_is_mc = 1'b0;
        bus.i_ex_rs = '0;  bus.i_ex_rs_used = '0; bus.i_ex_rd = '0;
        bus.i_ex_regwrite = 1'b0; bus.i_ex_is_load = 1'b0;
        bus.i_fwd_rd = '0; bus.i_fwd_regwrite = '0;
        bus.i_mc_start = 1'b0; bus.i_mc_rd = '0; bus.i_mc_lat = '0;
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        // Hazards present during reset must not show through.
        bus.i_ex_rs = {5'd0, 5'd5}; bus.i_ex_rs_used = 2'b01;
        bus.i_fwd_rd = {5'd5, 5'd5}; bus.i_fwd_regwrite = 2'b11;
        bus.i_ex_is_load = 1'b1; bus.i_ex_regwrite = 1'b1; bus.i_ex_rd = 5'd5;
        bus.i_de_rs = {5'd0, 5'd5}; bus.i_de_rs_used = 2'b01;
        @(posedge clk); #1;
        step("reset", 4'h0, 0, 0, 0, 0);
        rst_n = 1'b1;
        clear_inputs();
        step("idle", 4'h0, 0, 0, 0, 0);

        // Forwarding: youngest stage wins, x0 / unused never forwarded.
        bus.i_ex_rs = {5'd0, 5'd5}; bus.i_ex_rs_used = 2'b11;
        bus.i_fwd_rd = {5'd5, 5'd5}; bus.i_fwd_regwrite = 2'b11;
        step("t1_youngest", 4'h1, 0, 0, 0, 0);
        bus.i_fwd_regwrite = 2'b10;
        step("t1_memwb", 4'h2, 0, 0, 0, 0);
        bus.i_ex_rs = {5'd0, 5'd3}; bus.i_fwd_rd = {5'd3, 5'd0}; bus.i_fwd_regwrite = 2'b11;
        step("t2_x0", 4'h2, 0, 0, 0, 0);
        bus.i_ex_rs = {5'd4, 5'd3}; bus.i_ex_rs_used = 2'b01; bus.i_fwd_rd = {5'd3, 5'd4};
        step("t2_unused", 4'h2, 0, 0, 0, 0);
        bus.i_ex_rs_used = 2'b11;
        step("t2_used", 4'h6, 0, 0, 0, 0);
        clear_inputs();

        // Load-use: one stall cycle, then forwarding from EX/MEM.
        bus.i_ex_is_load = 1'b1; bus.i_ex_regwrite = 1'b1; bus.i_ex_rd = 5'd7;
        bus.i_de_rs = {5'd2, 5'd7}; bus.i_de_rs_used = 2'b11;
        step("t3_loaduse", 4'h0, 1, 0, 0, 0);
        clear_inputs();
        bus.i_ex_rs = {5'd2, 5'd7}; bus.i_ex_rs_used = 2'b11;
        bus.i_fwd_rd = {5'd0, 5'd7}; bus.i_fwd_regwrite = 2'b01;
        step("t3_fwd", 4'h1, 0, 0, 0, 0);
        clear_inputs();
        bus.i_ex_is_load = 1'b1; bus.i_ex_regwrite = 1'b1; bus.i_ex_rd = 5'd7;
        bus.i_de_rs = {5'd2, 5'd7}; bus.i_de_rs_used = 2'b10;
        step("t3_notused", 4'h0, 0, 0, 0, 0);
        clear_inputs();

        // Multicycle rd=9 lat=4 with a dependent DE instruction.
        bus.i_mc_start = 1'b1; bus.i_mc_rd = 5'd9; bus.i_mc_lat = 6'd4;
        wbq.push_back(5'd9);
        step("t4_issue", 4'h0, 0, 0, 0, 0);
        clear_inputs();
        bus.i_de_rs = {5'd0, 5'd9}; bus.i_de_rs_used = 2'b01;
        step("t4_c1", 4'h0, 1, 1, 0, 0);
        step("t4_c2", 4'h0, 1, 1, 0, 0);
        step("t4_c3", 4'h0, 1, 1, 0, 0);
        step("t4_c4", 4'h0, 1, 1, 1, 0);
        step("t4_c5", 4'h0, 0, 0, 0, 0);
        clear_inputs();

        // Back-to-back multicycle issue stalls while busy.
        bus.i_mc_start = 1'b1; bus.i_mc_rd = 5'd12; bus.i_mc_lat = 6'd2;
        wbq.push_back(5'd12);
        step("t4b_issue", 4'h0, 0, 0, 0, 0);
        clear_inputs();
        bus.i_de_is_mc = 1'b1;
        step("t4b_c1", 4'h0, 1, 1, 0, 0);
        step("t4b_c2", 4'h0, 1, 1, 1, 0);
        step("t4b_c3", 4'h0, 0, 0, 0, 0);
        clear_inputs();

        // Latency 0 behaves as 1.
        bus.i_mc_start = 1'b1; bus.i_mc_rd = 5'd10; bus.i_mc_lat = 6'd0;
        wbq.push_back(5'd10);
        step("t5_issue0", 4'h0, 0, 0, 0, 0);
        clear_inputs();
        step("t5_c1", 4'h0, 0, 1, 1, 0);
        step("t5_c2", 4'h0, 0, 0, 0, 0);

        // Issue while busy: error latches, entry in flight unchanged.
        bus.i_mc_start = 1'b1; bus.i_mc_rd = 5'd11; bus.i_mc_lat = 6'd3;
        wbq.push_back(5'd11);
        step("t5_issue", 4'h0, 0, 0, 0, 0);
        bus.i_mc_rd = 5'd13; bus.i_mc_lat = 6'd5;
        step("t5_dup", 4'h0, 0, 1, 0, 0);
        clear_inputs();
        step("t5_c2", 4'h0, 0, 1, 0, 1);
        step("t5_c3", 4'h0, 0, 1, 1, 1);
        step("t5_c4", 4'h0, 0, 0, 0, 1);

        // Reset while the countdown is at 2: entry dropped, no write-back.
        bus.i_mc_start = 1'b1; bus.i_mc_rd = 5'd14; bus.i_mc_lat = 6'd3;
        step("t6_issue", 4'h0, 0, 0, 0, 1);
        clear_inputs();
        step("t6_c1", 4'h0, 0, 1, 0, 1);
        rst_n = 1'b0;
        model_cnt = 0;
        step("t6_rst", 4'h0, 0, 0, 0, 0);
        rst_n = 1'b1;
        step("t6_after", 4'h0, 0, 0, 0, 0);
        step("t6_after2", 4'h0, 0, 0, 0, 0);

        // Hold a load-use stall long enough to saturate the 4-bit counter.
        bus.i_ex_is_load = 1'b1; bus.i_ex_regwrite = 1'b1; bus.i_ex_rd = 5'd7;
        bus.i_de_rs = {5'd0, 5'd7}; bus.i_de_rs_used = 2'b01;
        for (int i = 0; i < 18; i++) begin
            step($sformatf("t6_sat%0d", i), 4'h0, 1, 0, 0, 0);
        end
        clear_inputs();
        step("t6_hold", 4'h0, 0, 0, 0, 0);

        // Let the monitor drain, with a bound.
        for (int i = 0; i < 10 && expq.size() > 0; i++) @(negedge clk);
        #1;
        chk("expq_drained", expq.size(), 0);
        chk("wbq_drained", wbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
